// File: rtl/ex_mem_pkg.sv
// Shared encodings, width defaults and beat layout for the EX/MEM pipeline slice.
package ex_mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 3;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_RSVD = 2'b11
    } br_type_e;

    // Beat layout at the default widths; the stage packs fields in this order.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] result;
        logic [DATA_W_DEF-1:0] store_data;
        logic [REG_AW_DEF-1:0] rd_addr;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
    } beat_t;

    function automatic int beat_width(input int dw, input int aw);
        return (2 * dw) + aw + 3;
    endfunction

    function automatic logic branch_taken(input logic [1:0] br_type, input logic zero);
        logic taken;
        case (br_type_e'(br_type))
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ex_mem_skid.sv
// Generic two-entry skid buffer: main entry drives the outputs, skid entry
// absorbs the one beat accepted while main is blocked.
module ex_mem_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             main_valid_r;
    logic             skid_valid_r;
    logic             in_ready_r;
    logic [WIDTH-1:0] main_data_r;
    logic [WIDTH-1:0] skid_data_r;

    logic             main_valid_s;
    logic             skid_valid_s;
    logic [WIDTH-1:0] main_data_s;
    logic [WIDTH-1:0] skid_data_s;
    logic             accept_s;
    logic             main_free_s;

    // Next-state for both entries; skid always refills main first to keep order.
    always_comb begin
        accept_s     = in_valid & in_ready_r;
        main_free_s  = ~main_valid_r | out_ready;
        main_valid_s = main_valid_r;
        main_data_s  = main_data_r;
        skid_valid_s = skid_valid_r;
        skid_data_s  = skid_data_r;
        if (main_free_s) begin
            if (skid_valid_r) begin
                main_valid_s = 1'b1;
                main_data_s  = skid_data_r;
                skid_valid_s = 1'b0;
            end else if (accept_s) begin
                main_valid_s = 1'b1;
                main_data_s  = in_data;
            end else begin
                main_valid_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_valid_s = 1'b1;
                skid_data_s  = in_data;
            end else begin
                skid_valid_s = skid_valid_r;
            end
        end
    end

    // Entry registers; in_ready is registered from the next skid occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            main_data_r  <= '0;
            skid_data_r  <= '0;
        end else begin
            main_valid_r <= main_valid_s;
            skid_valid_r <= skid_valid_s;
            in_ready_r   <= ~skid_valid_s;
            main_data_r  <= main_data_s;
            skid_data_r  <= skid_data_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch redirect, stall counter and optional
// forwarding tap (enabled by defining EX_MEM_FWD_EN).
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    input  logic [1:0]        br_type,
    input  logic [DATA_W-1:0] br_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_reg_write,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [15:0]       stall_cnt,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int BEAT_W = beat_width(DATA_W, REG_AW);

    logic [BEAT_W-1:0] in_beat_s;
    logic [BEAT_W-1:0] out_beat_s;
    logic              accept_s;
    logic              taken_s;
    logic              stall_s;
    logic              redirect_valid_r;
    logic [DATA_W-1:0] redirect_pc_r;
    logic [15:0]       stall_cnt_r;

    // Branches travel as ordinary beats; control bits are not altered.
    assign in_beat_s = {alu_result, store_data, rd_addr, mem_read, mem_write, reg_write};

    ex_mem_skid #(
        .WIDTH(BEAT_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_beat_s),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_beat_s),
        .out_ready(out_ready)
    );

    assign {out_result, out_store_data, out_rd_addr,
            out_mem_read, out_mem_write, out_reg_write} = out_beat_s;

    assign accept_s = in_valid & in_ready;
    assign taken_s  = branch_taken(br_type, alu_zero);
    assign stall_s  = out_valid & ~out_ready;

    // Redirect pulses one cycle after a taken branch is accepted, regardless of MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= '0;
        end else begin
            redirect_valid_r <= accept_s & taken_s;
            if (accept_s && taken_s) begin
                redirect_pc_r <= br_target;
            end
        end
    end

    // Saturating count of cycles MEM holds off a valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign stall_cnt      = stall_cnt_r;

`ifdef EX_MEM_FWD_EN
    // Loads are excluded: their data is not known until MEM completes.
    assign fwd_valid = out_valid & out_reg_write & ~out_mem_read;
    assign fwd_addr  = out_rd_addr;
    assign fwd_data  = out_result;
`else
    assign fwd_valid = 1'b0;
    assign fwd_addr  = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized bench for ex_mem_stage against a queue-based model of the stage.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] alu_result = 16'h0000;
    logic        alu_zero = 1'b0;
    logic [15:0] store_data = 16'h0000;
    logic [2:0]  rd_addr = 3'd0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        reg_write = 1'b0;
    logic [1:0]  br_type = 2'b00;
    logic [15:0] br_target = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [15:0] out_store_data;
    logic [2:0]  out_rd_addr;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_reg_write;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] stall_cnt;
    logic        fwd_valid;
    logic [2:0]  fwd_addr;
    logic [15:0] fwd_data;

    typedef struct {
        logic [15:0] res;
        logic [15:0] sd;
        logic [2:0]  rd;
        logic        mr;
        logic        mw;
        logic        rw;
    } mb_t;

    mb_t         mq[$];
    logic        m_redir = 1'b0;
    logic [15:0] m_rpc = 16'h0000;
    int          m_stall = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_zero(alu_zero), .store_data(store_data),
        .rd_addr(rd_addr), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .br_type(br_type), .br_target(br_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_store_data(out_store_data), .out_rd_addr(out_rd_addr),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_reg_write(out_reg_write), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stall_cnt(stall_cnt), .fwd_valid(fwd_valid),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data)
    );

    // Model: a FIFO of at most two held beats; front is what MEM must see.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_redir = 1'b0;
                m_rpc   = 16'h0000;
                m_stall = 0;
            end else begin
                int  cnt;
                bit  acc;
                bit  tk;
                mb_t b;
                cnt = mq.size();
                acc = in_valid && (cnt < 2);
                tk  = ((br_type == 2'b01) && alu_zero) || ((br_type == 2'b10) && !alu_zero);
                if ((cnt > 0) && !out_ready && (m_stall < 65535)) m_stall = m_stall + 1;
                if ((cnt > 0) && out_ready) void'(mq.pop_front());
                if (acc) begin
                    b.res = alu_result; b.sd = store_data; b.rd = rd_addr;
                    b.mr = mem_read; b.mw = mem_write; b.rw = reg_write;
                    mq.push_back(b);
                end
                m_redir = acc && tk;
                if (acc && tk) m_rpc = br_target;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] res, input logic [15:0] sd,
                         input logic [2:0] rd, input logic mr, input logic mw, input logic rw,
                         input logic [1:0] bt, input logic z, input logic [15:0] tgt);
        in_valid = v; alu_result = res; store_data = sd; rd_addr = rd;
        mem_read = mr; mem_write = mw; reg_write = rw;
        br_type = bt; alu_zero = z; br_target = tgt;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000);
    endtask

    initial begin
        // Per-cycle comparison of every meaningful output against the model.
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    logic exp_fv;
                    check("in_ready", in_ready, mq.size() < 2);
                    check("out_valid", out_valid, mq.size() > 0);
                    exp_fv = 1'b0;
                    if (mq.size() > 0) begin
                        check("out_result", out_result, mq[0].res);
                        check("out_store_data", out_store_data, mq[0].sd);
                        check("out_rd_addr", out_rd_addr, mq[0].rd);
                        check("out_ctrl", {out_mem_read, out_mem_write, out_reg_write},
                              {mq[0].mr, mq[0].mw, mq[0].rw});
                        exp_fv = mq[0].rw && !mq[0].mr;
                    end
                    check("redirect_valid", redirect_valid, m_redir);
                    if (m_redir) check("redirect_pc", redirect_pc, m_rpc);
                    check("stall_cnt", stall_cnt, m_stall);
`ifdef EX_MEM_FWD_EN
                    check("fwd_valid", fwd_valid, exp_fv);
                    if (exp_fv) begin
                        check("fwd_addr", fwd_addr, mq[0].rd);
                        check("fwd_data", fwd_data, mq[0].res);
                    end
`else
                    check("fwd_tied", {fwd_valid, fwd_addr, fwd_data}, 20'h00000);
`endif
                end
            end
        join_none

        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_redirect", {redirect_valid, redirect_pc}, 17'h00000);
        check("rst_stall_cnt", stall_cnt, 16'h0000);
        check("rst_data", {out_result, out_store_data, out_rd_addr}, 35'h0);
        check("rst_fwd_valid", fwd_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rel_in_ready", in_ready, 1'b1);

        // Single beat appears the next cycle.
        out_ready = 1'b1;
        drive(1'b1, 16'h0005, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000);
        tick();
        check("lat_out_valid", out_valid, 1'b1);
        check("lat_out_result", out_result, 16'h0005);
        check("lat_out_rd_addr", out_rd_addr, 3'd3);
        idle();
        tick();
        check("drain_out_valid", out_valid, 1'b0);

        // Backpressure fills skid, then drains in order.
        out_ready = 1'b0;
        drive(1'b1, 16'h0011, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000);
        tick();
        drive(1'b1, 16'h0022, 16'h0000, 3'd2, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000);
        tick();
        check("skid_in_ready", in_ready, 1'b0);
        check("skid_main_a", out_result, 16'h0011);
        idle();
        out_ready = 1'b1;
        tick();
        check("skid_main_b", out_result, 16'h0022);
        check("skid_valid_b", out_valid, 1'b1);
        check("skid_in_ready_back", in_ready, 1'b1);
        tick();
        check("skid_empty", out_valid, 1'b0);

        // Taken BEQ pulses once; BNE with zero set does not.
        drive(1'b1, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 16'h0040);
        tick();
        check("beq_redirect", redirect_valid, 1'b1);
        check("beq_pc", redirect_pc, 16'h0040);
        drive(1'b1, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 16'h0080);
        tick();
        check("bne_no_redirect", redirect_valid, 1'b0);
        check("bne_ctrl_pass", out_mem_write, 1'b1);
        idle();
        tick();

`ifdef EX_MEM_FWD_EN
        drive(1'b1, 16'h0777, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000);
        tick();
        check("fwd_load", fwd_valid, 1'b0);
        drive(1'b1, 16'h1234, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000);
        tick();
        check("fwd_add_valid", fwd_valid, 1'b1);
        check("fwd_add_addr", fwd_addr, 3'd5);
        idle();
        tick();
`endif

        // Random traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                  16'($urandom));
            out_ready = $urandom_range(0, 9) < 6;
            tick();
        end

        // Long stall saturates the counter.
        out_ready = 1'b0;
        drive(1'b1, 16'h00AA, 16'h0000, 3'd4, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0000);
        tick();
        idle();
        repeat (70000) tick();
        check("stall_sat", stall_cnt, 16'hFFFF);
        check("stall_valid", out_valid, 1'b1);

        // Reset with both entries full and a redirect pulse showing.
        drive(1'b1, 16'h00BB, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 16'h0100);
        tick();
        idle();
        check("pre_rst_in_ready", in_ready, 1'b0);
        check("pre_rst_redirect", redirect_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_redirect", redirect_valid, 1'b0);
        check("mid_rst_stall", stall_cnt, 16'h0000);
        check("mid_rst_result", out_result, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
